// File: rtl/udp_tx_arbiter_if.sv
// Bundles the per-source request bus and the single UDP transmit handshake.
// The arbiter connects through the master modport; the environment
// (packet sources plus UDP transmitter) uses the slave modport.
interface udp_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 7680
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*16-1:0]     req_length;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_drop;
    logic                      udp_send_data_valid;
    logic [DATA_W-1:0]         udp_send_data;
    logic [15:0]               udp_send_data_length;
    logic                      udp_send_data_ready;

    modport master (
        input  req_valid, req_data, req_length, udp_send_data_ready,
        output req_done, req_drop, udp_send_data_valid, udp_send_data,
               udp_send_data_length
    );

    modport slave (
        output req_valid, req_data, req_length, udp_send_data_ready,
        input  req_done, req_drop, udp_send_data_valid, udp_send_data,
               udp_send_data_length
    );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter that shares one UDP transmit port between NUM_REQ
// packet sources. One packet is in flight at a time, a fixed idle gap
// follows each packet, and a watchdog drops packets the transmitter never
// accepts. Illegal lengths are dropped straight from IDLE without touching
// the downstream port. The interface instance must use the same NUM_REQ and
// DATA_W as this module.
module udp_tx_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_W     = 7680,
    parameter int MAX_LEN    = 960,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic                       rgmii_clk,
    input  logic                       rst,
    udp_tx_arbiter_if.master           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);
    localparam int          ID_W     = $clog2(NUM_REQ);
    localparam int          GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int          GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] LEN_MAX  = 16'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t              state;
    logic [ID_W-1:0]     last_grant;
    logic [15:0]         tmo_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic                send_valid;
    logic [DATA_W-1:0]   send_data;
    logic [15:0]         send_len;
    logic [NUM_REQ-1:0]  done_q;
    logic [NUM_REQ-1:0]  drop_q;

    logic                found;
    logic [ID_W-1:0]     idx;
    logic [ID_W-1:0]     pick;
    logic [15:0]         pick_len;
    logic [DATA_W-1:0]   pick_data;
    logic                pick_bad;

    // Pick the first valid source after the previous grant, and mux out its length and payload.
    always_comb begin
        found     = 1'b0;
        idx       = '0;
        pick      = '0;
        pick_len  = '0;
        pick_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + 1 + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == ID_W'(k)) begin
                pick_len  = bus.req_length[k*16 +: 16];
                pick_data = bus.req_data[k*DATA_W +: DATA_W];
            end
        end
        pick_bad = (pick_len == 16'd0) || (pick_len > LEN_MAX);
    end

    // Arbitration and send sequencing FSM; every output is a register here.
    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            grant_id   <= '0;
            busy       <= 1'b0;
            send_valid <= 1'b0;
            send_data  <= '0;
            send_len   <= '0;
            done_q     <= '0;
            drop_q     <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            done_q <= '0;
            drop_q <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        last_grant <= pick;
                        if (pick_bad) begin
                            drop_q[pick] <= 1'b1;
                        end else begin
                            send_data <= pick_data;
                            send_len  <= pick_len;
                            grant_id  <= pick;
                            tmo_cnt   <= '0;
                            busy      <= 1'b1;
                            state     <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (!send_valid) begin
                        send_valid <= 1'b1;
                    end else if (bus.udp_send_data_ready || tmo_cnt == TMO_LAST) begin
                        if (bus.udp_send_data_ready) begin
                            done_q[grant_id] <= 1'b1;
                        end else begin
                            drop_q[grant_id] <= 1'b1;
                        end
                        send_valid <= 1'b0;
                        tmo_cnt    <= '0;
                        gap_cnt    <= '0;
                        if (GAP_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end else if (tmo_cnt != 16'hFFFF) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.udp_send_data_valid  = send_valid;
    assign bus.udp_send_data        = send_data;
    assign bus.udp_send_data_length = send_len;
    assign bus.req_done             = done_q;
    assign bus.req_drop             = drop_q;
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: each request pushes its expected
// outcome onto a per-source queue; grants, held data and done/drop pulses
// are checked against the queue heads as the arbiter produces them.
module tb_udp_tx_arbiter;
    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 64;
    localparam int MAX_LEN = 960;
    localparam int GAP     = 16;
    localparam int TMO     = 100;

    typedef struct {
        bit          inval;
        bit          drop;
        logic [63:0] data;
        logic [15:0] len;
        int          rdy;
        int          cycles;
    } exp_t;

    logic       rgmii_clk = 1'b0;
    logic       rst;
    logic [0:0] grant_id;
    logic       busy;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        cur;
    int          grant_log[$];
    int          rise_log[$];
    int          vcnt;
    int          cycle;
    bit          prev_valid;
    int          checks;
    int          errors;
    int          rearm[2];
    logic [63:0] last_data[2];
    logic [15:0] last_len[2];
    int          last_rdy[2];
    int          gl;

    // Free-running transmit-domain clock.
    always #5 rgmii_clk = ~rgmii_clk;

    udp_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    udp_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN),
        .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .rgmii_clk(rgmii_clk),
        .rst(rst),
        .bus(bus),
        .grant_id(grant_id),
        .busy(busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t peek(input int i);
        if (i == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic popq(input int i, output exp_t e);
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    // Raise a request and record the outcome the arbiter should give it.
    task automatic applyStimulus(input int src, input logic [63:0] data, input logic [15:0] len, input int rdy);
        exp_t e;
        e.data  = data;
        e.len   = len;
        e.rdy   = rdy;
        e.inval = (len == 16'd0) || (len > 16'(MAX_LEN));
        if (e.inval) begin
            e.drop   = 1'b1;
            e.cycles = 0;
        end else if (rdy == 0 || rdy > TMO) begin
            e.drop   = 1'b1;
            e.cycles = TMO;
        end else begin
            e.drop   = 1'b0;
            e.cycles = rdy;
        end
        if (src == 0) q0.push_back(e);
        else          q1.push_back(e);
        last_data[src] = data;
        last_len[src]  = len;
        last_rdy[src]  = rdy;
        bus.req_data[src*DATA_W +: DATA_W] = data;
        bus.req_length[src*16 +: 16]       = len;
        bus.req_valid[src]                 = 1'b1;
    endtask

    // One clock: monitor outputs, play requester and transmitter roles.
    task automatic tick();
        bit   pulsed[2];
        exp_t e;
        @(posedge rgmii_clk);
        #1;
        cycle++;
        pulsed = '{1'b0, 1'b0};
        if (bus.udp_send_data_valid && !prev_valid) begin
            grant_log.push_back(int'(grant_id));
            rise_log.push_back(cycle);
            checkOutput("grant_pending", 64'(qsize(int'(grant_id))), 64'd1);
            if (qsize(int'(grant_id)) > 0) begin
                cur = peek(int'(grant_id));
                checkOutput("grant_legal", 64'(cur.inval), 64'd0);
                checkOutput("grant_len", 64'(bus.udp_send_data_length), 64'(cur.len));
                checkOutput("grant_data", bus.udp_send_data, cur.data);
            end else begin
                cur = '{default: '0};
            end
            vcnt = 0;
        end
        if (bus.udp_send_data_valid) begin
            vcnt++;
            if (vcnt > 1) begin
                checkOutput("hold_data", bus.udp_send_data, cur.data);
                checkOutput("hold_len", 64'(bus.udp_send_data_length), 64'(cur.len));
            end
        end
        if (!bus.udp_send_data_valid && prev_valid && cur.cycles != 0)
            checkOutput("valid_cycles", 64'(vcnt), 64'(cur.cycles));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_done[i] || bus.req_drop[i]) begin
                checkOutput("pulse_pending", 64'(qsize(i)), 64'd1);
                if (qsize(i) > 0) begin
                    popq(i, e);
                    checkOutput("pulse_kind", 64'({bus.req_done[i], bus.req_drop[i]}), e.drop ? 64'd1 : 64'd2);
                end
                bus.req_valid[i] = 1'b0;
                pulsed[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!bus.req_valid[i] && !pulsed[i] && rearm[i] > 0) begin
                rearm[i]--;
                applyStimulus(i, last_data[i], last_len[i], last_rdy[i]);
            end
        end
        bus.udp_send_data_ready = bus.udp_send_data_valid && cur.rdy != 0 && vcnt == cur.rdy;
        prev_valid = bus.udp_send_data_valid;
    endtask

    // Test sequence.
    initial begin
        checks = 0;
        errors = 0;
        cycle  = 0;
        vcnt   = 0;
        prev_valid = 1'b0;
        cur    = '{default: '0};
        rearm  = '{0, 0};
        rst    = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_length = '0;
        bus.udp_send_data_ready = 1'b0;
        repeat (3) tick();

        // Reset values.
        checkOutput("rst_valid", 64'(bus.udp_send_data_valid), 64'd0);
        checkOutput("rst_data", bus.udp_send_data, 64'd0);
        checkOutput("rst_len", 64'(bus.udp_send_data_length), 64'd0);
        checkOutput("rst_done", 64'(bus.req_done), 64'd0);
        checkOutput("rst_drop", 64'(bus.req_drop), 64'd0);
        checkOutput("rst_grant", 64'(grant_id), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();

        // Fairness: both sources continuously requesting, ready after one cycle.
        $display("[TB] fairness");
        grant_log.delete();
        rise_log.delete();
        rearm = '{2, 2};
        applyStimulus(0, 64'h1111_1111_1111_1111, 16'd100, 1);
        applyStimulus(1, 64'h2222_2222_2222_2222, 16'd200, 1);
        for (int n = 0; n < 400 && !(q0.size() == 0 && q1.size() == 0 && rearm[0] == 0 && rearm[1] == 0 && !busy); n++)
            tick();
        checkOutput("fair_count", 64'(grant_log.size()), 64'd6);
        for (int k = 0; k < grant_log.size(); k++)
            checkOutput("fair_order", 64'(grant_log[k]), 64'(k % 2));
        for (int k = 1; k < rise_log.size(); k++)
            checkOutput("fair_spacing", 64'(rise_log[k] - rise_log[k-1]), 64'(3 + GAP));

        // Single source at MAX_LEN, payload changed while in SEND.
        $display("[TB] single source");
        applyStimulus(0, {8{8'hAA}}, 16'd960, 5);
        tick();
        checkOutput("lat_valid_n1", 64'(bus.udp_send_data_valid), 64'd0);
        checkOutput("lat_busy", 64'(busy), 64'd1);
        tick();
        checkOutput("lat_valid_n2", 64'(bus.udp_send_data_valid), 64'd1);
        checkOutput("single_grant", 64'(grant_id), 64'd0);
        checkOutput("single_len", 64'(bus.udp_send_data_length), 64'h03C0);
        bus.req_data[63:0] = {8{8'h55}};
        for (int n = 0; n < 50 && !bus.req_done[0]; n++) tick();
        checkOutput("single_done", 64'(bus.req_done[0]), 64'd1);
        tick();
        checkOutput("done_width", 64'(bus.req_done), 64'd0);
        repeat (14) tick();
        checkOutput("gap_busy", 64'(busy), 64'd1);
        tick();
        checkOutput("gap_idle", 64'(busy), 64'd0);

        // Watchdog drop, then source 1 gets the next grant.
        $display("[TB] timeout");
        applyStimulus(0, 64'hDEAD_BEEF_0000_0001, 16'd64, 0);
        for (int n = 0; n < 10 && !bus.udp_send_data_valid; n++) tick();
        applyStimulus(1, 64'hBEEF_CAFE_0000_0002, 16'd32, 3);
        for (int n = 0; n < 200 && !bus.req_drop[0]; n++) tick();
        checkOutput("tmo_drop", 64'(bus.req_drop), 64'd1);
        checkOutput("tmo_valid", 64'(bus.udp_send_data_valid), 64'd0);
        gl = grant_log.size();
        for (int n = 0; n < 50 && grant_log.size() <= gl; n++) tick();
        checkOutput("tmo_next_count", 64'(grant_log.size()), 64'(gl + 1));
        if (grant_log.size() > gl) checkOutput("tmo_next_grant", 64'(grant_log[gl]), 64'd1);
        for (int n = 0; n < 100 && (busy || q1.size() != 0); n++) tick();

        // Illegal lengths are dropped from IDLE.
        $display("[TB] invalid length");
        applyStimulus(1, 64'h0123_4567_89AB_CDEF, 16'd0, 3);
        tick();
        checkOutput("inval0_drop", 64'(bus.req_drop), 64'd2);
        checkOutput("inval0_valid", 64'(bus.udp_send_data_valid), 64'd0);
        checkOutput("inval0_busy", 64'(busy), 64'd0);
        tick();
        applyStimulus(1, 64'h0123_4567_89AB_CDEF, 16'd961, 3);
        tick();
        checkOutput("inval961_drop", 64'(bus.req_drop), 64'd2);
        checkOutput("inval961_valid", 64'(bus.udp_send_data_valid), 64'd0);
        tick();
        checkOutput("inval_drop_width", 64'(bus.req_drop), 64'd0);
        checkOutput("inval_valid_after", 64'(bus.udp_send_data_valid), 64'd0);

        // Ready arriving on the timeout cycle wins.
        $display("[TB] coincidence");
        applyStimulus(0, 64'hC0FF_EE00_C0FF_EE00, 16'd500, TMO);
        for (int n = 0; n < 200 && !(bus.req_done[0] || bus.req_drop[0]); n++) tick();
        checkOutput("coin_done", 64'(bus.req_done), 64'd1);
        checkOutput("coin_drop", 64'(bus.req_drop), 64'd0);
        for (int n = 0; n < 50 && busy; n++) tick();

        // Reset three cycles into SEND, then source 0 wins again.
        $display("[TB] reset mid-send");
        applyStimulus(0, 64'h7777_0000_7777_0000, 16'd10, 0);
        for (int n = 0; n < 10 && !bus.udp_send_data_valid; n++) tick();
        tick();
        tick();
        checkOutput("pre_rst_valid", 64'(bus.udp_send_data_valid), 64'd1);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        cur.cycles = 0;
        cur.rdy    = 0;
        tick();
        checkOutput("mid_rst_valid", 64'(bus.udp_send_data_valid), 64'd0);
        checkOutput("mid_rst_done", 64'(bus.req_done), 64'd0);
        checkOutput("mid_rst_drop", 64'(bus.req_drop), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        bus.req_valid = '0;
        tick();
        gl = grant_log.size();
        applyStimulus(1, 64'h0000_1111_0000_1111, 16'd20, 2);
        applyStimulus(0, 64'h0000_2222_0000_2222, 16'd30, 2);
        for (int n = 0; n < 200 && (q0.size() != 0 || q1.size() != 0 || busy); n++) tick();
        checkOutput("post_rst_count", 64'(grant_log.size()), 64'(gl + 2));
        if (grant_log.size() >= gl + 2) begin
            checkOutput("post_rst_first", 64'(grant_log[gl]), 64'd0);
            checkOutput("post_rst_second", 64'(grant_log[gl+1]), 64'd1);
        end

        checkOutput("sb_empty", 64'(q0.size() + q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
